// File: rtl/spi_rx_byte_packer.sv
// Packs the SPI master's received-bit stream into DATA_W-bit words and buffers them
// in a first-word-fall-through FIFO with valid/ready output and sticky error flags.
module spi_rx_byte_packer #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          frame_active_i,
    input  logic                          bit_valid_i,
    input  logic                          bit_i,
    input  logic                          clr_i,
    output logic [DATA_W-1:0]             byte_data_o,
    output logic                          byte_valid_o,
    input  logic                          byte_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          overflow_o,
    output logic                          partial_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = $clog2(DATA_W);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_ABORT   = 2'd2;

    logic [1:0]        state_q;
    logic              frame_prev_q;
    logic [BC_W-1:0]   bit_cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_nxt;
    logic              word_done;
    logic              push;
    logic              pop;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    // NOTE: every signal driven in always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        shift_nxt = MSB_FIRST ? {shift_q[DATA_W-2:0], bit_i} : {bit_i, shift_q[DATA_W-1:1]};
        word_done = (state_q == ST_COLLECT) && frame_active_i && bit_valid_i &&
                    (bit_cnt_q == BC_W'(DATA_W - 1));
        pop       = byte_valid_o & byte_ready_i;
        push      = word_done & ((count_q < CNT_W'(FIFO_DEPTH)) | pop);
    end

    // frame_prev resets high so a frame already active at reset release is skipped.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            frame_prev_q <= 1'b1;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
        end else begin
            frame_prev_q <= frame_active_i;
            case (state_q)
                ST_IDLE: begin
                    if (frame_active_i && !frame_prev_q) begin
                        shift_q   <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (!frame_active_i) begin
                        state_q <= (bit_cnt_q != '0) ? ST_ABORT : ST_IDLE;
                    end else if (bit_valid_i) begin
                        shift_q   <= shift_nxt;
                        bit_cnt_q <= word_done ? '0 : bit_cnt_q + 1'b1;
                    end
                end
                ST_ABORT: begin
                    shift_q   <= '0;
                    bit_cnt_q <= '0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: storage array has no reset; occupancy is tracked by count_q and empty output is forced to 0.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= shift_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as clr_i wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o <= 1'b0;
            partial_o  <= 1'b0;
        end else begin
            overflow_o <= (word_done & ~push) | (overflow_o & ~clr_i);
            partial_o  <= (state_q == ST_ABORT) | (partial_o & ~clr_i);
        end
    end

    assign byte_valid_o = (count_q != '0);
    assign byte_data_o  = byte_valid_o ? mem[rd_ptr_q] : '0;
    assign fifo_count_o = count_q;

endmodule

// File: tb/tb_spi_rx_byte_packer.sv
// Scoreboard bench for spi_rx_byte_packer: a frame/bit-list reference model predicts
// accepted words and flags; a separate monitor checks every word the DUT hands out.
module tb_spi_rx_byte_packer;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam bit MSB_FIRST  = 1'b1;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    logic              clk;
    logic              rst_ni;
    logic              frame_active;
    logic              bit_valid;
    logic              bit_in;
    logic              clr;
    logic [DATA_W-1:0] byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic [CNT_W-1:0]  fifo_count;
    logic              overflow;
    logic              partial;

    spi_rx_byte_packer #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .MSB_FIRST (MSB_FIRST)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .frame_active_i(frame_active),
        .bit_valid_i   (bit_valid),
        .bit_i         (bit_in),
        .clr_i         (clr),
        .byte_data_o   (byte_data),
        .byte_valid_o  (byte_valid),
        .byte_ready_i  (byte_ready),
        .fifo_count_o  (fifo_count),
        .overflow_o    (overflow),
        .partial_o     (partial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: frame-level view of the stream.
    int                m_cnt;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] got_q[$];
    bit                bits_q[$];
    bit                m_ovf, m_partial, m_pend, m_capt, m_prev, m_dead;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] pack_bits();
        int w = 0;
        for (int i = 0; i < DATA_W; i++) begin
            if (MSB_FIRST) w += int'(bits_q[i]) << (DATA_W - 1 - i);
            else           w += int'(bits_q[i]) << i;
        end
        return DATA_W'(w);
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        exp_q.delete();
        bits_q.delete();
        m_ovf = 0; m_partial = 0; m_pend = 0; m_capt = 0; m_prev = 1; m_dead = 0;
    endtask

    // One clock: drive inputs, predict the edge, then check settled outputs.
    task automatic step(input bit fa, input bit bv, input bit b, input bit rdy, input bit cl);
        bit                pop;
        bit                push;
        logic [DATA_W-1:0] w;
        frame_active = fa; bit_valid = bv; bit_in = b; byte_ready = rdy; clr = cl;
        pop  = (m_cnt > 0) && rdy;
        push = 0;
        if (cl) begin m_ovf = 0; m_partial = 0; end
        if (m_pend) begin m_partial = 1; m_pend = 0; end
        if (m_capt) begin
            if (!fa) begin
                if (bits_q.size() != 0) begin m_pend = 1; m_dead = 1; end
                bits_q.delete();
                m_capt = 0;
            end else if (bv) begin
                bits_q.push_back(b);
                if (bits_q.size() == DATA_W) begin
                    w = pack_bits();
                    bits_q.delete();
                    if (m_cnt < FIFO_DEPTH || pop) begin exp_q.push_back(w); push = 1; end
                    else m_ovf = 1;
                end
            end
        end else if (m_dead) begin
            m_dead = 0;
        end else if (fa && !m_prev) begin
            m_capt = 1;
            bits_q.delete();
        end
        m_prev = fa;
        m_cnt += int'(push) - int'(pop);
        @(posedge clk);
        #1;
        check("fifo_count", 32'(fifo_count), 32'(m_cnt));
        check("byte_valid", 32'(byte_valid), 32'(m_cnt != 0));
        check("overflow",   32'(overflow),   32'(m_ovf));
        check("partial",    32'(partial),    32'(m_partial));
        if (m_cnt == 0) check("empty_data", 32'(byte_data), 32'h0);
    endtask

    task automatic do_reset(input bit fa);
        rst_ni = 1'b0;
        frame_active = fa; bit_valid = 0; bit_in = 0; byte_ready = 0; clr = 0;
        model_reset();
        #1;
        check("rst_count",    32'(fifo_count), 32'h0);
        check("rst_valid",    32'(byte_valid), 32'h0);
        check("rst_data",     32'(byte_data),  32'h0);
        check("rst_overflow", 32'(overflow),   32'h0);
        check("rst_partial",  32'(partial),    32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, rdy, 0);
    endtask

    task automatic send_bits(input int n, input logic [63:0] v, input int gap, input bit rdy);
        for (int i = n - 1; i >= 0; i--) begin
            for (int g = 0; g < gap; g++) step(1, 0, 0, rdy, 0);
            step(1, 1, v[i], rdy, 0);
        end
    endtask

    task automatic check_got(input string name, input logic [DATA_W-1:0] want[$]);
        check({name, "_count"}, 32'(got_q.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < got_q.size(); i++)
            check(name, 32'(got_q[i]), 32'(want[i]));
        got_q.delete();
    endtask

    // Monitor: every accepted head word is compared against the scoreboard queue.
    always @(negedge clk) begin
        if (rst_ni && byte_valid && byte_ready) begin
            if (exp_q.size() == 0) check("scoreboard_underflow", 32'(byte_valid), 32'h0);
            else check("word", 32'(byte_data), 32'(exp_q.pop_front()));
            got_q.push_back(byte_data);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset(0);

        // Two words with back-to-back bits, consumer always ready.
        idle(2, 1); step(1, 0, 0, 1, 0);
        send_bits(16, 64'hA53C, 0, 1);
        idle(3, 1);
        check_got("t1_words", '{8'hA5, 8'h3C});

        // Same stream, one bit every third cycle.
        idle(2, 1); step(1, 0, 0, 1, 0);
        send_bits(16, 64'hA53C, 2, 1);
        idle(3, 1);
        check_got("t2_words", '{8'hA5, 8'h3C});

        // Five words into a stalled four-entry FIFO, then drain and clear.
        idle(2, 0); step(1, 0, 0, 0, 0);
        send_bits(40, 64'h0102030405, 0, 0);
        idle(3, 0);
        check("t3_count", 32'(fifo_count), 32'd4);
        idle(8, 1);
        check_got("t3_words", '{8'h01, 8'h02, 8'h03, 8'h04});
        step(0, 0, 0, 1, 1);

        // Short frame aborts, next frame packs from a fresh word.
        idle(2, 1); step(1, 0, 0, 1, 0);
        send_bits(3, 64'h5, 0, 1);
        idle(3, 1); step(1, 0, 0, 1, 0);
        send_bits(8, 64'hC3, 0, 1);
        idle(3, 1);
        check("t4_partial", 32'(partial), 32'h1);
        check_got("t4_words", '{8'hC3});
        step(0, 0, 0, 1, 1);

        // Full FIFO: fifth word completes on the same edge as a pop.
        idle(2, 0); step(1, 0, 0, 0, 0);
        send_bits(32, 64'h11223344, 0, 0);
        send_bits(7, 64'h55 >> 1, 0, 0);
        send_bits(1, 64'h1, 0, 1);
        check("t5_count", 32'(fifo_count), 32'd4);
        idle(3, 0);
        idle(8, 1);
        check_got("t5_words", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});

        // Reset mid-frame with the frame held active; no capture until a new rising edge.
        idle(2, 1); step(1, 0, 0, 1, 0);
        send_bits(5, 64'h15, 0, 1);
        do_reset(1);
        send_bits(10, 64'h2AB, 0, 1);
        idle(2, 1); step(1, 0, 0, 1, 0);
        send_bits(8, 64'h96, 0, 1);
        idle(3, 1);
        check_got("t6_words", '{8'h96});
        idle(2, 0); step(1, 0, 0, 0, 0);
        send_bits(40, 64'hDEADBEEF77, 0, 0);
        idle(2, 0);
        step(0, 0, 0, 0, 1);
        check("t6_clr_overflow", 32'(overflow), 32'h0);
        idle(8, 1);
        got_q.delete();

        // Randomized frames: lengths, bit spacing, back-pressure, clears and short gaps.
        for (int f = 0; f < 40; f++) begin
            int len = $urandom_range(1, 40);
            int gap = $urandom_range(0, 2);
            int pre = $urandom_range(1, 3);
            for (int i = 0; i < pre; i++)
                step(0, 1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
            step(1, 1'($urandom), 1'($urandom), 1'($urandom), 0);
            for (int i = 0; i < len; i++) begin
                for (int g = 0; g < gap; g++)
                    step(1, 0, 0, 1'($urandom), ($urandom_range(0, 15) == 0));
                step(1, 1, 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
            end
            step(0, 1'($urandom), 1'($urandom), 1'($urandom), 0);
        end
        idle(10, 1);
        check("final_scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
